sram_rw_pipe_ext: RTL
=====================

Name: sram_rw_pipe_ext

Overview:
- Parametrised single-port (RW0) masked behavioural SRAM. Next generation of the fixed-geometry *_ext macros.
- Adds configurable depth, width and mask granularity, a pipelined read latency with a valid strobe, and a post-reset self-initialisation sweep.
- Used as the backing store for caches, directories and tag arrays where memory contents must be deterministic after reset.

Parameters:
- ADDR_W, 10, address width in bits.
- DEPTH, 1024, number of words; 2 <= DEPTH <= 2**ADDR_W.
- DATA_W, 64, word width in bits.
- MASK_W, 8, write-mask lanes; DATA_W % MASK_W == 0; lane width LANE_W = DATA_W/MASK_W.
- RD_LAT, 1, read latency in cycles from acceptance to rvalid; legal range 1..4.
- INIT_VAL, 0, DATA_W-bit value written to every word during initialisation.

Ports:
- RW0_clk  in  1  clock; all state changes on the rising edge.
- RW0_rst_n  in  1  reset, asynchronous, active-low.
- RW0_addr  in  ADDR_W  word address.
- RW0_en  in  1  request strobe.
- RW0_wmode  in  1  1 = write, 0 = read.
- RW0_wmask  in  MASK_W  per-lane write enable; bit i covers wdata[i*LANE_W +: LANE_W].
- RW0_wdata  in  DATA_W  write data.
- RW0_ready  out  1  request accepted when RW0_en && RW0_ready.
- RW0_rvalid  out  1  one-cycle pulse marking valid RW0_rdata.
- RW0_rdata  out  DATA_W  read data.
- init_done  out  1  high once initialisation completes; stays high until the next reset.

Behaviour:
- Reset (asserted): state=INIT, init_cnt=0, RW0_ready=0, RW0_rvalid=0, RW0_rdata=0, init_done=0, read pipeline valids cleared.
- The memory array itself is not reset.
- FSM states: INIT and RUN.
- INIT:
  - Each cycle writes INIT_VAL to ram[init_cnt] and increments init_cnt.
  - The cycle that writes init_cnt==DEPTH-1 transitions to RUN.
  - The sweep takes exactly DEPTH cycles after reset deassertion.
  - RW0_en is ignored in INIT: the request is dropped, with no write and no rvalid.
- RUN: RW0_ready=1 and init_done=1, both registered from the first RUN cycle. There is no path back to INIT except reset.
- Read accept at edge T:
  - ram[addr] is sampled at T. A write accepted at T+1 or later cannot alter it.
  - RW0_rvalid=1 and RW0_rdata=data in the cycle following edge T+RD_LAT-1. RD_LAT=1 means data appears in the cycle after acceptance.
  - Fully pipelined: one read per cycle, rvalid back-to-back.
- Write accept at edge T:
  - Lanes with wmask[i]=1 are updated at T; other lanes are unchanged.
  - wmask=0 is a legal no-op.
  - A write produces no rvalid.
- Read of an address written at T, accepted at T+1 or later, returns the new data.
- A single port means no same-cycle read/write collision.
- Out-of-range addr (addr >= DEPTH):
  - A write is dropped.
  - A read returns INIT_VAL with rvalid asserted as normal.
- RW0_rdata when RW0_rvalid=0: see Optional Feature.
- Reset asserted mid-operation:
  - In-flight reads are discarded; no rvalid is emitted after reset.
  - The memory is fully re-initialised by a new sweep.

Optional Feature:
- Macro: SRAM_RDATA_HOLD_EN.
- Defined: RW0_rdata holds the last valid read data until the next rvalid. The reset value remains 0.
- Undefined: RW0_rdata is driven to 0 in every cycle where RW0_rvalid=0.

Decomposition:
- Package sram_pkg holds:
  - typedef sram_state_e {INIT, RUN};
  - constants RD_LAT_MIN=1 and RD_LAT_MAX=4;
  - a function lane_w(DATA_W, MASK_W).
- Sub-module sram_rd_pipe: an RD_LAT-1 stage valid+data delay line with async active-low reset on the valid bits only. It is instantiated after the array read register.
- The FSM, array and mask logic stay in the top level.

Test Plan:
1. Reset, then poll: with DEPTH=16 and INIT_VAL=0xA5A5, init_done rises exactly 16 cycles after deassertion; reading addr 0..15 returns 0xA5A5 each.
2. Masked write: write addr 3 with data 0x1122334455667788 and full mask, then with data 0xFFFF...FF and mask 0x0F; a read returns 0x11223344FFFFFFFF.
3. Latency/pipelining: RD_LAT=3, reads of addrs 1,2,3 on consecutive cycles; rvalid is high on cycles T+3..T+5 with the data in order.
4. Write-after-read: read addr 5 (old=0x10) at T, write 0x20 at T+1; the read returns 0x10, and a read at T+2 returns 0x20.
5. Requests during INIT and out-of-range: en=1 during the sweep gives no rvalid and no memory change. With DEPTH=12 and ADDR_W=4, a write to addr 13 is dropped and a read of it returns INIT_VAL.
6. Reset mid-read: assert RW0_rst_n=0 with 2 reads in flight; no rvalid appears, the sweep restarts, and a prior write is overwritten with INIT_VAL. Run with and without SRAM_RDATA_HOLD_EN and check rdata between pulses (held vs 0).

Source files
------------

// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared types and helpers for the sram_rw_pipe_ext macro family.
//   sram_state_e : controller state (INIT sweep, RUN service)
//   RD_LAT_MIN/MAX : legal range of the read-latency parameter
//   lane_w()     : width of one write-mask lane
// -----------------------------------------------------------------------------
package sram_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } sram_state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    function automatic int lane_w(input int data_w, input int mask_w);
        return data_w / mask_w;
    endfunction

endpackage

// File: rtl/sram_rw_pipe_ext_rd_pipe.sv
// -----------------------------------------------------------------------------
// sram_rd_pipe
// Valid+data delay line placed after the array read register. STAGES extra
// register stages are inserted; STAGES=0 is a wire-through. Only the valid
// bits are reset, so in-flight reads vanish on reset while the data path
// stays reset-free.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_valid, i_data  read result entering the delay line
//   o_valid, o_data  read result leaving the delay line
// -----------------------------------------------------------------------------
module sram_rd_pipe #(
    parameter int STAGES = 0,
    parameter int DATA_W = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = i_clk & i_rst_n;
            assign o_valid = i_valid;
            assign o_data  = i_data;
        end else begin : g_stages
            logic              w_vld [STAGES+1];
            logic [DATA_W-1:0] w_dat [STAGES+1];

            assign w_vld[0] = i_valid;
            assign w_dat[0] = i_data;

            for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
                logic              r_vld;
                logic [DATA_W-1:0] r_dat;

                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        r_vld <= 1'b0;
                    end else begin
                        r_vld <= w_vld[gi];
                    end
                end

                // Data only moves with a valid beat; idle cycles leave it alone.
                always_ff @(posedge i_clk) begin
                    if (w_vld[gi]) begin
                        r_dat <= w_dat[gi];
                    end
                end

                assign w_vld[gi+1] = r_vld;
                assign w_dat[gi+1] = r_dat;
            end

            assign o_valid = w_vld[STAGES];
            assign o_data  = w_dat[STAGES];
        end
    endgenerate

endmodule

// File: rtl/sram_rw_pipe_ext.sv
// -----------------------------------------------------------------------------
// sram_rw_pipe_ext
// Parametrised single-port masked SRAM with pipelined reads and a post-reset
// initialisation sweep that writes INIT_VAL to every word.
// Ports:
//   RW0_clk, RW0_rst_n  clock, asynchronous active-low reset
//   RW0_addr            word address (addr >= DEPTH: write dropped,
//                       read returns INIT_VAL)
//   RW0_en, RW0_wmode   request strobe, 1 = write / 0 = read
//   RW0_wmask           per-lane write enable
//   RW0_wdata           write data
//   RW0_ready           high in RUN; request accepted on en && ready
//   RW0_rvalid          one-cycle pulse, RD_LAT cycles after read accept
//   RW0_rdata           read data
//   init_done           high once the sweep has finished
// Build option:
//   SRAM_RDATA_HOLD_EN  defined   : rdata holds the last valid read data
//                       undefined : rdata is 0 whenever rvalid is 0
// RD_LAT must lie in RD_LAT_MIN..RD_LAT_MAX.
// -----------------------------------------------------------------------------
module sram_rw_pipe_ext
    import sram_pkg::*;
#(
    parameter int              ADDR_W   = 10,
    parameter int              DEPTH    = 1024,
    parameter int              DATA_W   = 64,
    parameter int              MASK_W   = 8,
    parameter int              RD_LAT   = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              RW0_clk,
    input  logic              RW0_rst_n,
    input  logic [ADDR_W-1:0] RW0_addr,
    input  logic              RW0_en,
    input  logic              RW0_wmode,
    input  logic [MASK_W-1:0] RW0_wmask,
    input  logic [DATA_W-1:0] RW0_wdata,
    output logic              RW0_ready,
    output logic              RW0_rvalid,
    output logic [DATA_W-1:0] RW0_rdata,
    output logic              init_done
);

    localparam int                LANE_W   = lane_w(DATA_W, MASK_W);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Controller: INIT sweep then RUN forever (until reset)
    // ------------------------------------------------------------------
    sram_state_e       r_state;
    logic [ADDR_W-1:0] r_init_cnt;
    logic              r_ready;
    logic              r_init_done;

    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            r_state     <= INIT;
            r_init_cnt  <= '0;
            r_ready     <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == LAST_IDX) begin
                        r_state     <= RUN;
                        r_ready     <= 1'b1;
                        r_init_done <= 1'b1;
                    end
                end
                RUN: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state <= INIT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Request decode. ready is low throughout INIT, so requests made
    // during the sweep are simply never accepted.
    // ------------------------------------------------------------------
    logic w_accept;
    logic w_in_range;
    logic w_wr_en;
    logic w_rd_en;

    assign w_accept   = RW0_en & r_ready;
    assign w_in_range = ({1'b0, RW0_addr} < DEPTH_X);
    assign w_wr_en    = w_accept & RW0_wmode & w_in_range;
    assign w_rd_en    = w_accept & ~RW0_wmode;

    // The sweep and user writes share the single array write port.
    logic              w_sweep;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic [MASK_W-1:0] w_lane_we;

    assign w_sweep   = (r_state == INIT);
    assign w_wr_addr = w_sweep ? r_init_cnt : RW0_addr;
    assign w_wr_data = w_sweep ? INIT_VAL   : RW0_wdata;

    generate
        for (genvar gi = 0; gi < MASK_W; gi++) begin : g_lane_we
            assign w_lane_we[gi] = w_sweep | (w_wr_en & RW0_wmask[gi]);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Storage: not reset; contents become defined through the sweep.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge RW0_clk) begin
        for (int i = 0; i < MASK_W; i++) begin
            if (w_lane_we[i]) begin
                r_mem[w_wr_addr][i*LANE_W +: LANE_W] <= w_wr_data[i*LANE_W +: LANE_W];
            end
        end
    end

    // Registered array read. The out-of-range substitution is applied
    // after the register so the read itself stays a plain RAM read.
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_oor;
    logic              r_rd_valid;
    logic [DATA_W-1:0] w_rd_word;

    always_ff @(posedge RW0_clk) begin
        if (w_rd_en) begin
            r_rd_data <= r_mem[RW0_addr];
            r_rd_oor  <= ~w_in_range;
        end
    end

    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_en;
        end
    end

    assign w_rd_word = r_rd_oor ? INIT_VAL : r_rd_data;

    // ------------------------------------------------------------------
    // Remaining RD_LAT-1 stages of latency
    // ------------------------------------------------------------------
    logic              w_pipe_valid;
    logic [DATA_W-1:0] w_pipe_data;

    sram_rd_pipe #(
        .STAGES (RD_LAT - 1),
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .i_clk   (RW0_clk),
        .i_rst_n (RW0_rst_n),
        .i_valid (r_rd_valid),
        .i_data  (w_rd_word),
        .o_valid (w_pipe_valid),
        .o_data  (w_pipe_data)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
`ifdef SRAM_RDATA_HOLD_EN
    logic [DATA_W-1:0] r_rdata_hold;

    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            r_rdata_hold <= '0;
        end else if (w_pipe_valid) begin
            r_rdata_hold <= w_pipe_data;
        end
    end

    assign RW0_rdata = w_pipe_valid ? w_pipe_data : r_rdata_hold;
`else
    assign RW0_rdata = w_pipe_valid ? w_pipe_data : '0;
`endif

    assign RW0_rvalid = w_pipe_valid;
    assign RW0_ready  = r_ready;
    assign init_done  = r_init_done;

endmodule
